instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 83 ++++++++
 rtl/instr_encoder_if.sv | 30 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/instr_encoder.sv | 72 +++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared MIPS op enum, opcode/funct constants, field widths, encoder function
// Purpose: single source of truth for instruction encoding values shared with decoders.
// Contents: field widths, op_e enum, opcode/funct constants, enc_t result struct, encode().
package instr_encoder_pkg;

    localparam int OP_W    = 4;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int OPC_W   = 6;
    localparam int FUNCT_W = 6;
    localparam int WORD_W  = 32;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_JR   = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9,
        OP_ADDI = 4'd10,
        OP_J    = 4'd11,
        OP_JAL  = 4'd12
    } op_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;
    localparam logic [FUNCT_W-1:0] FUNCT_JR  = 6'h08;

    typedef struct packed {
        logic              legal;
        logic [WORD_W-1:0] word;
    } enc_t;

    function automatic enc_t encode(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [IMM_W-1:0] imm,
        input logic [TGT_W-1:0] tgt
    );
        enc_t r;
        r.legal = 1'b1;
        case (op_e'(op))
            OP_ADD:  r.word = {OPC_RTYPE, rs, rt, rd, 5'h0, FUNCT_ADD};
            OP_SUB:  r.word = {OPC_RTYPE, rs, rt, rd, 5'h0, FUNCT_SUB};
            OP_AND:  r.word = {OPC_RTYPE, rs, rt, rd, 5'h0, FUNCT_AND};
            OP_OR:   r.word = {OPC_RTYPE, rs, rt, rd, 5'h0, FUNCT_OR};
            OP_SLT:  r.word = {OPC_RTYPE, rs, rt, rd, 5'h0, FUNCT_SLT};
            OP_JR:   r.word = {OPC_RTYPE, rs, 15'h0, FUNCT_JR};
            OP_LW:   r.word = {OPC_LW, rs, rt, imm};
            OP_SW:   r.word = {OPC_SW, rs, rt, imm};
            OP_BEQ:  r.word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:  r.word = {OPC_BNE, rs, rt, imm};
            OP_ADDI: r.word = {OPC_ADDI, rs, rt, imm};
            OP_J:    r.word = {OPC_J, tgt};
            OP_JAL:  r.word = {OPC_JAL, tgt};
            default: begin
                r.legal = 1'b0;
                r.word  = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory handshake bundle
// Purpose: groups the encode-request stream and the memory-write stream.
// slave modport: encoder side (consumes requests, produces memory writes).
// master modport: requester / memory side.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic [REG_W-1:0]  in_rd;
    logic [IMM_W-1:0]  in_imm;
    logic [TGT_W-1:0]  in_target;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_addr;
    logic [WORD_W-1:0] out_data;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and synchronous flush
// Ports: clk, reset (async, active-high), flush, wr_en/wr_data, rd_en/rd_data (head entry), count.
// Caller guarantees wr_en only when not full and rd_en only when not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder feeding an instruction-memory write stream
// Ports: clk, reset (async, active-high), flush (sync clear), bus (slave: request in,
// memory write out), count (FIFO occupancy), err (sticky illegal-op flag).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    instr_encoder_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    enc_t              enc;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    assign enc = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_target);

    assign bus.in_ready  = (count < DEPTH_C) && !flush;
    assign bus.out_valid = (count != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    // Illegal ops are consumed from the request stream but never queued.
    assign wr_en         = accept && enc.legal;
    // Flush wins over a pending output transfer.
    assign rd_en         = bus.out_valid && bus.out_ready && !flush;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (enc.word),
        .rd_en   (rd_en),
        .rd_data (bus.out_data),
        .count   (count)
    );

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        if (flush)      addr_d = BASE_ADDR;
        else if (rd_en) addr_d = addr_q + 32'd4;
        // err survives flush; only reset clears it.
        if (accept && !enc.legal) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign bus.out_addr = addr_q;
    assign err          = err_q;
endmodule
